morse_encoder: RTL and testbench

Transmit-side counterpart to the decoder's display buffer path. It takes a 64-bit buffer of up to eight 8-bit character codes, in the same layout the display buffer uses, and keys them out as International Morse timing on a single `tone` line for the LED or buzzer. Characters are consumed from the low byte upward, one byte shifted out per character. The first `8'h00` byte ends transmission.

---
 rtl/morse_encoder.sv | 197 +++++++++++++++++++
 tb/tb_morse_encoder.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/morse_encoder.sv
// Keys a captured 64-bit buffer of up to eight character codes out as International Morse on `tone`.
// Bytes are consumed low byte first; the first 8'h00 ends the transmission.
module morse_encoder #(
   parameter int UNIT_CYCLES = 25_000_000,
   parameter int CNT_W       = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [63:0] chars_in,
   output logic        busy,
   output logic        done,
   output logic        tone,
   output logic [2:0]  char_idx
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LOAD = 3'd1,
      S_MARK = 3'd2,
      S_SGAP = 3'd3,
      S_CGAP = 3'd4,
      S_WGAP = 3'd5,
      S_FIN  = 3'd6
   } state_t;

   localparam logic [CNT_W-1:0] LAST_1U = CNT_W'(UNIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] LAST_3U = CNT_W'(3 * UNIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] LAST_4U = CNT_W'(4 * UNIT_CYCLES - 1);

   // Pattern ROM: {length, symbols}; symbol 0 in bit 0, 1 = dash; length 0 = not a Morse character.
   function automatic logic [7:0] morse_rom(input logic [7:0] code);
      logic [7:0] rom;
      case (code)
         8'h41: rom = {3'd2, 5'b00010}; // A
         8'h42: rom = {3'd4, 5'b00001};
         8'h43: rom = {3'd4, 5'b00101};
         8'h44: rom = {3'd3, 5'b00001};
         8'h45: rom = {3'd1, 5'b00000};
         8'h46: rom = {3'd4, 5'b00100};
         8'h47: rom = {3'd3, 5'b00011};
         8'h48: rom = {3'd4, 5'b00000};
         8'h49: rom = {3'd2, 5'b00000};
         8'h4A: rom = {3'd4, 5'b01110};
         8'h4B: rom = {3'd3, 5'b00101};
         8'h4C: rom = {3'd4, 5'b00010};
         8'h4D: rom = {3'd2, 5'b00011};
         8'h4E: rom = {3'd2, 5'b00001};
         8'h4F: rom = {3'd3, 5'b00111};
         8'h50: rom = {3'd4, 5'b00110};
         8'h51: rom = {3'd4, 5'b01011};
         8'h52: rom = {3'd3, 5'b00010};
         8'h53: rom = {3'd3, 5'b00000};
         8'h54: rom = {3'd1, 5'b00001};
         8'h55: rom = {3'd3, 5'b00100};
         8'h56: rom = {3'd4, 5'b01000};
         8'h57: rom = {3'd3, 5'b00110};
         8'h58: rom = {3'd4, 5'b01001};
         8'h59: rom = {3'd4, 5'b01101};
         8'h5A: rom = {3'd4, 5'b00011};
         8'h30: rom = {3'd5, 5'b11111}; // 0
         8'h31: rom = {3'd5, 5'b11110};
         8'h32: rom = {3'd5, 5'b11100};
         8'h33: rom = {3'd5, 5'b11000};
         8'h34: rom = {3'd5, 5'b10000};
         8'h35: rom = {3'd5, 5'b00000};
         8'h36: rom = {3'd5, 5'b00001};
         8'h37: rom = {3'd5, 5'b00011};
         8'h38: rom = {3'd5, 5'b00111};
         8'h39: rom = {3'd5, 5'b01111};
         default: rom = {3'd0, 5'b00000};
      endcase
      return rom;
   endfunction

   state_t            state_q, state_d;
   logic [63:0]       buf_q, buf_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [4:0]        sym_q, sym_d;
   logic [2:0]        left_q, left_d;
   logic [2:0]        idx_q, idx_d;
   logic              tone_q, tone_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [7:0]        rom_s;

   // Next-state, datapath and registered-output decode.
   always_comb begin
      state_d = state_q;
      buf_d   = buf_q;
      cnt_d   = cnt_q;
      sym_d   = sym_q;
      left_d  = left_q;
      idx_d   = idx_q;
      rom_s   = morse_rom(buf_q[7:0]);
      case (state_q)
         S_IDLE: begin
            if (start) begin
               buf_d   = chars_in;
               idx_d   = 3'd0;
               cnt_d   = {CNT_W{1'b0}};
               state_d = S_LOAD;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_LOAD: begin
            cnt_d = {CNT_W{1'b0}};
            if (buf_q[7:0] == 8'h00) begin
               state_d = S_FIN;
            end else if (rom_s[7:5] != 3'd0) begin
               sym_d   = rom_s[4:0];
               left_d  = rom_s[7:5];
               state_d = S_MARK;
            end else if (buf_q[7:0] == 8'h20) begin
               state_d = S_WGAP;
            end else begin
               // Unsupported code: drop it at the cost of this one LOAD cycle.
               buf_d = {8'h00, buf_q[63:8]};
               idx_d = idx_q + 3'd1;
            end
         end
         S_MARK: begin
            if (cnt_q == (sym_q[0] ? LAST_3U : LAST_1U)) begin
               cnt_d = {CNT_W{1'b0}};
               if (left_q > 3'd1) begin
                  sym_d   = {1'b0, sym_q[4:1]};
                  left_d  = left_q - 3'd1;
                  state_d = S_SGAP;
               end else begin
                  state_d = S_CGAP;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_SGAP: begin
            if (cnt_q == LAST_1U) begin
               cnt_d   = {CNT_W{1'b0}};
               state_d = S_MARK;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_CGAP, S_WGAP: begin
            if (cnt_q == ((state_q == S_CGAP) ? LAST_3U : LAST_4U)) begin
               cnt_d   = {CNT_W{1'b0}};
               buf_d   = {8'h00, buf_q[63:8]};
               idx_d   = idx_q + 3'd1;
               state_d = S_LOAD;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_FIN: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      tone_d = (state_d == S_MARK);
      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_FIN);
   end

   // State, datapath and output registers; reset drops the key line at once.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         buf_q   <= 64'h0;
         cnt_q   <= {CNT_W{1'b0}};
         sym_q   <= 5'd0;
         left_q  <= 3'd0;
         idx_q   <= 3'd0;
         tone_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         buf_q   <= buf_d;
         cnt_q   <= cnt_d;
         sym_q   <= sym_d;
         left_q  <= left_d;
         idx_q   <= idx_d;
         tone_q  <= tone_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign tone     = tone_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign char_idx = idx_q;

endmodule

// File: tb/tb_morse_encoder.sv
// Bench for morse_encoder: a dot/dash string model expands each buffer into a per-cycle
// expectation queue that one compare process checks against the DUT on every falling edge.
module tb_morse_encoder;
   localparam int U = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [63:0] chars_in = 64'h0;
   logic        busy, done, tone;
   logic [2:0]  char_idx;

   morse_encoder #(.UNIT_CYCLES(U), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .start(start), .chars_in(chars_in),
      .busy(busy), .done(done), .tone(tone), .char_idx(char_idx)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       busy;
      logic       done;
      logic       tone;
      logic [2:0] idx;
      logic       chk_idx;
   } exp_t;

   exp_t mq[$];
   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic string morse(input logic [7:0] c);
      case (c)
         "A": return ".-";    "B": return "-...";  "C": return "-.-.";  "D": return "-..";
         "E": return ".";     "F": return "..-.";  "G": return "--.";   "H": return "....";
         "I": return "..";    "J": return ".---";  "K": return "-.-";   "L": return ".-..";
         "M": return "--";    "N": return "-.";    "O": return "---";   "P": return ".--.";
         "Q": return "--.-";  "R": return ".-.";   "S": return "...";   "T": return "-";
         "U": return "..-";   "V": return "...-";  "W": return ".--";   "X": return "-..-";
         "Y": return "-.--";  "Z": return "--..";
         "0": return "-----"; "1": return ".----"; "2": return "..---"; "3": return "...--";
         "4": return "....-"; "5": return "....."; "6": return "-...."; "7": return "--...";
         "8": return "---.."; "9": return "----.";
         default: return "";
      endcase
   endfunction

   task automatic push(input int n, input logic b, input logic d, input logic t,
                       input int idx, input logic ci);
      exp_t e;
      e.busy = b; e.done = d; e.tone = t; e.idx = 3'(idx); e.chk_idx = ci;
      for (int i = 0; i < n; i++) mq.push_back(e);
   endtask

   // Expected behaviour from cycle t0+1 up to and including the first IDLE cycle.
   task automatic model(input logic [63:0] b);
      string      s;
      logic [7:0] c;
      int         k;
      mq.delete();
      k = 0;
      while (k < 8 && b[8*k +: 8] != 8'h00) begin
         c = b[8*k +: 8];
         s = morse(c);
         push(1, 1'b1, 1'b0, 1'b0, k, 1'b1);
         if (s.len() > 0) begin
            for (int j = 0; j < s.len(); j++) begin
               push((s[j] == "-") ? 3 * U : U, 1'b1, 1'b0, 1'b1, k, 1'b1);
               if (j < s.len() - 1) push(U, 1'b1, 1'b0, 1'b0, k, 1'b1);
            end
            push(3 * U, 1'b1, 1'b0, 1'b0, k, 1'b1);
         end else if (c == 8'h20) begin
            push(4 * U, 1'b1, 1'b0, 1'b0, k, 1'b1);
         end else begin
            k = k;
         end
         k++;
      end
      push(1, 1'b1, 1'b0, 1'b0, k, 1'b1);
      push(1, 1'b1, 1'b1, 1'b0, k, 1'b1);
      push(1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
   endtask

   function automatic int tone_count();
      int n = 0;
      foreach (mq[i]) if (mq[i].tone) n++;
      return n;
   endfunction

   function automatic int first_done();
      foreach (mq[i]) if (mq[i].done) return i;
      return -1;
   endfunction

   function automatic int first_tone();
      foreach (mq[i]) if (mq[i].tone) return i;
      return -1;
   endfunction

   function automatic int max_inner_gap();
      int run = 0, mx = 0;
      bit seen = 1'b0;
      foreach (mq[i]) begin
         if (mq[i].tone) begin
            if (seen && run > mx) mx = run;
            run = 0;
            seen = 1'b1;
         end else begin
            run++;
         end
      end
      return mx;
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("busy", busy, e.busy);
         chk("done", done, e.done);
         chk("tone", tone, e.tone);
         if (e.chk_idx) chk("char_idx", char_idx, e.idx);
      end
   end

   // Called at a falling edge + 2; returns at the same phase of the first IDLE cycle after FIN.
   task automatic run_tx(input logic [63:0] b, input bit perturb);
      bit fin = 1'b0;
      model(b);
      chars_in = b;
      start = 1'b1;
      @(posedge clk);
      exp_q = mq;
      #1 start = 1'b0;
      if (perturb) chars_in = {$urandom, $urandom};
      for (int i = 0; i < 3000 && !fin; i++) begin
         @(negedge clk);
         #2 start = 1'b0;
         if (exp_q.size() == 0) fin = 1'b1;
         else if (perturb && exp_q.size() > 2 && $urandom_range(0, 15) == 0) begin
            start = 1'b1;
            chars_in = {$urandom, $urandom};
         end
      end
      if (!fin) begin
         chk("timeout", exp_q.size(), 0);
         exp_q.delete();
      end
   endtask

   function automatic logic [63:0] rand_buf();
      logic [63:0] b = 64'h0;
      int r;
      for (int k = 0; k < 8; k++) begin
         r = $urandom_range(0, 99);
         if (r < 45)      b[8*k +: 8] = 8'(8'h41 + $urandom_range(0, 25));
         else if (r < 65) b[8*k +: 8] = 8'(8'h30 + $urandom_range(0, 9));
         else if (r < 75) b[8*k +: 8] = 8'h20;
         else if (r < 88) b[8*k +: 8] = 8'($urandom_range(1, 255));
         else             b[8*k +: 8] = 8'h00;
      end
      return b;
   endfunction

   initial begin
      int sz_b;
      bit seen;
      // Hand-computed expectations that pin the model itself.
      model(64'h45);
      chk("E_len", mq.size(), 12);
      chk("E_done_at", first_done() + 1, 11);
      chk("E_tone_first", first_tone() + 1, 2);
      chk("E_tone_cycles", tone_count(), 2);
      model(64'h4F53);
      chk("SO_tone_cycles", tone_count(), 24);
      model(64'h422041);
      chk("AB_word_gap", max_inner_gap(), 7 * U + 2);
      model(64'h42);
      sz_b = mq.size();
      model(64'h4221);
      chk("bang_cost", mq.size() - sz_b, 1);
      model(64'h0);
      chk("empty_len", mq.size(), 3);
      chk("empty_done_at", first_done() + 1, 2);

      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_tone", tone, 0);
      chk("rst_idx", char_idx, 0);
      @(negedge clk);
      @(negedge clk);
      #2 rst = 1'b1;
      @(negedge clk);
      #2;

      run_tx(64'h45, 1'b0);
      run_tx(64'h4F53, 1'b0);
      run_tx(64'h422041, 1'b0);
      run_tx(64'h4221, 1'b0);
      run_tx(64'h0, 1'b0);
      run_tx(64'h3332314F4C4C4548, 1'b1);
      run_tx(64'h00000000000000A7, 1'b0);

      // Reset during the dash of "T".
      chars_in = 64'h54;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 50 && !seen; i++) begin
         @(negedge clk);
         if (tone) seen = 1'b1;
      end
      chk("dash_seen", seen, 1);
      @(negedge clk);
      #1 rst = 1'b0;
      #1;
      chk("async_tone", tone, 0);
      chk("async_busy", busy, 0);
      chk("async_done", done, 0);
      chk("async_idx", char_idx, 0);
      @(negedge clk);
      #2 rst = 1'b1;
      @(negedge clk);
      #2;
      run_tx(64'h4B, 1'b0);

      for (int n = 0; n < 25; n++) run_tx(rand_buf(), 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
